// File: rtl/rc_stream_sequencer.sv
// Stream-side sequencer for the dual-batch ReinforcedConcrete core: load 2x39 words, run, read back.
// Optional WAIT_DONE watchdog is compiled in with `define RC_WATCHDOG_EN.
module rc_stream_sequencer #(
    parameter int N_BITS         = 254,
    parameter int BATCH_WORDS    = 39,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_BITS-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [N_BITS-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_BITS-1:0] core_in,
    output logic [1:0]        core_wr,
    output logic [1:0]        core_rd,
    output logic              core_enable,
    output logic              core_reset,
    input  logic [N_BITS-1:0] core_out,
    input  logic              core_done,
    output logic              busy,
    output logic              err
);

    localparam logic [6:0] BATCH_CNT = 7'(BATCH_WORDS);
    localparam logic [6:0] LAST_WORD = 7'(2 * BATCH_WORDS - 1);

    typedef enum logic [2:0] {
        S_CLEAR,
        S_LOAD,
        S_START,
        S_WAIT_DONE,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_RD_CAP,
        S_OUT
    } state_t;

    state_t              state_q, state_d;
    logic [6:0]          cnt_q, cnt_d;
    logic                core_reset_q, core_reset_d;
    logic [N_BITS-1:0]   core_in_q, core_in_d;
    logic [1:0]          core_wr_q, core_wr_d;
    logic [1:0]          core_rd_q, core_rd_d;
    logic                core_enable_q, core_enable_d;
    logic [N_BITS-1:0]   out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic [1:0]          batch_sel;

`ifdef RC_WATCHDOG_EN
    localparam int TIMER_W = ($clog2(TIMEOUT_CYCLES + 1) > 13) ? $clog2(TIMEOUT_CYCLES + 1) : 13;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic                err_q, err_d;
`endif

    // The same counter walks both the write and the read pass, so one select serves both.
    assign batch_sel = (cnt_q < BATCH_CNT) ? 2'b01 : 2'b10;

    always_comb begin
        // NOTE: every _d gets a default before the case so no path can infer a latch.
        state_d       = state_q;
        cnt_d         = cnt_q;
        core_reset_d  = core_reset_q;
        core_in_d     = core_in_q;
        core_wr_d     = 2'b00;
        core_rd_d     = 2'b00;
        core_enable_d = core_enable_q;
        out_data_d    = out_data_q;
        out_valid_d   = out_valid_q;
`ifdef RC_WATCHDOG_EN
        timer_d       = timer_q;
        err_d         = err_q;
`endif
        case (state_q)
            S_CLEAR: begin
                // cnt doubles as the two-cycle core reset timer.
                if (cnt_q == 7'd1) begin
                    state_d      = S_LOAD;
                    cnt_d        = 7'd0;
                    core_reset_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    core_in_d = in_data;
                    core_wr_d = batch_sel;
                    if (cnt_q == LAST_WORD) begin
                        state_d = S_START;
                        cnt_d   = 7'd0;
                    end else begin
                        cnt_d = cnt_q + 7'd1;
                    end
                end
            end
            S_START: begin
                core_enable_d = 1'b1;
                state_d       = S_WAIT_DONE;
`ifdef RC_WATCHDOG_EN
                timer_d       = '0;
`endif
            end
            S_WAIT_DONE: begin
                if (core_done) begin
                    core_enable_d = 1'b0;
                    state_d       = S_RD_ISSUE;
                end
`ifdef RC_WATCHDOG_EN
                else if (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
                    err_d         = 1'b1;
                    core_enable_d = 1'b0;
                    core_reset_d  = 1'b1;
                    cnt_d         = 7'd0;
                    state_d       = S_CLEAR;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
`endif
            end
            S_RD_ISSUE: begin
                core_rd_d = batch_sel;
                state_d   = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                // Core updates outState at the end of this cycle; capture one cycle later.
                state_d = S_RD_CAP;
            end
            S_RD_CAP: begin
                out_data_d  = core_out;
                out_valid_d = 1'b1;
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (cnt_q == LAST_WORD) begin
                        cnt_d        = 7'd0;
                        core_reset_d = 1'b1;
                        state_d      = S_CLEAR;
                    end else begin
                        cnt_d   = cnt_q + 7'd1;
                        state_d = S_RD_ISSUE;
                    end
                end
            end
            default: begin
                cnt_d        = 7'd0;
                core_reset_d = 1'b1;
                state_d      = S_CLEAR;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_CLEAR;
            cnt_q         <= 7'd0;
            core_reset_q  <= 1'b1;
            core_in_q     <= '0;
            core_wr_q     <= 2'b00;
            core_rd_q     <= 2'b00;
            core_enable_q <= 1'b0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
`ifdef RC_WATCHDOG_EN
            timer_q       <= '0;
            err_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            core_reset_q  <= core_reset_d;
            core_in_q     <= core_in_d;
            core_wr_q     <= core_wr_d;
            core_rd_q     <= core_rd_d;
            core_enable_q <= core_enable_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
`ifdef RC_WATCHDOG_EN
            timer_q       <= timer_d;
            err_q         <= err_d;
`endif
        end
    end

    assign in_ready    = (state_q == S_LOAD);
    assign busy        = !((state_q == S_LOAD) && (cnt_q == 7'd0));
    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign core_in     = core_in_q;
    assign core_wr     = core_wr_q;
    assign core_rd     = core_rd_q;
    assign core_enable = core_enable_q;
    assign core_reset  = core_reset_q;

`ifdef RC_WATCHDOG_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
